fruit_launcher: RTL

FRUIT_LAUNCHER -- requirements
Module: fruit_launcher

---
 rtl/fruit_launcher.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fruit_launcher.sv
// Launches one object along a ballistic arc with LFSR-randomised start column and velocity.
// Motion advances once every TICK_DIV clocks; x bounces off the screen edges.
module fruit_launcher #(
   parameter int          TICK_DIV = 833333,
   parameter int          GRAVITY  = 1,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       launch,
   input  logic [9:0] width,
   input  logic [8:0] height,
   output logic [9:0] posx,
   output logic [8:0] posy,
   output logic       visible,
   output logic       busy,
   output logic       done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic signed [10:0] GRAV      = 11'(GRAVITY);

   typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

   state_t             state, state_n;
   logic [15:0]        lfsr;
   logic [TW-1:0]      tick, tick_n;
   logic [9:0]         x, x_n, xmax, launch_x;
   logic signed [3:0]  vx, vx_n;
   logic signed [10:0] y, y_n, vy, vy_n;
   logic signed [10:0] xn, y_step, vy_step;
   logic               done_n;
   logic               height_unused;

   assign height_unused = ^height;
   assign posx = x;

   function automatic logic [8:0] clamp_y(input logic signed [10:0] v);
      if (v[10])              return 9'd0;
      else if (v > 11'sd479)  return 9'd479;
      else                    return v[8:0];
   endfunction

   function automatic logic signed [10:0] sat_vy(input logic signed [10:0] v);
      return (v > 11'sd15) ? 11'sd15 : v;
   endfunction

   always_comb begin
      state_n  = state;
      tick_n   = tick;
      x_n      = x;
      vx_n     = vx;
      y_n      = y;
      vy_n     = vy;
      done_n   = 1'b0;
      xmax     = (width >= 10'd640) ? 10'd0 : 10'd640 - width;
      launch_x = ({1'b0, lfsr[8:0]} > xmax) ? xmax : {1'b0, lfsr[8:0]};
      xn       = $signed({1'b0, x}) + $signed({{7{vx[3]}}, vx});
      y_step   = y + vy;
      vy_step  = sat_vy(vy + GRAV);

      case (state)
         IDLE: begin
            if (en && launch) begin
               x_n     = launch_x;
               vx_n    = $signed({lfsr[12], lfsr[12:10]});
               vy_n    = 11'sd0 - (11'sd12 + $signed({9'd0, lfsr[15:14]}));
               y_n     = 11'sd480;
               tick_n  = '0;
               state_n = RISE;
            end
         end
         default: begin
            if (en) begin
               if (tick == TICK_LAST) begin
                  tick_n = '0;
                  // Bounce: clamp to the edge and reverse horizontal velocity
                  if (xn[10]) begin
                     x_n  = 10'd0;
                     vx_n = -vx;
                  end else if (xn > $signed({1'b0, xmax})) begin
                     x_n  = xmax;
                     vx_n = -vx;
                  end else begin
                     x_n = xn[9:0];
                  end
                  y_n  = y_step;
                  vy_n = vy_step;
                  if (state == RISE && !vy_step[10]) begin
                     state_n = FALL;
                  end else if (state == FALL && y_step >= 11'sd480) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         lfsr    <= SEED;
         tick    <= '0;
         x       <= '0;
         vx      <= '0;
         y       <= 11'sd480;
         vy      <= '0;
         posy    <= 9'd479;
         visible <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         state   <= state_n;
         tick    <= tick_n;
         x       <= x_n;
         vx      <= vx_n;
         y       <= y_n;
         vy      <= vy_n;
         posy    <= clamp_y(y_n);
         visible <= (state_n != IDLE) && !y_n[10] && (y_n <= 11'sd479);
         busy    <= (state_n != IDLE);
         done    <= done_n;
      end
   end

endmodule
